usb_rx_pkt_ctrl: RTL and testbench
==================================

# usb_rx_pkt_ctrl

Packet-level controller that sequences the USB receiver datapath one level above the bit-level receive control unit. It consumes the per-byte strobe, data and error flags from the receiver, decodes and checks the PID, and classifies each packet as token, data or handshake. It forwards data-packet bytes (payload plus CRC16) into the RX FIFO and flushes them on error. It presents one packet result at a time to the protocol layer through a valid/ack handshake.

## Interface
- MAX_DATA, 64: maximum data-packet payload bytes, excluding CRC; legal range 1..125.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rcving  in  1  receiver busy; high from SYNC detect until EOP handled.
- w_enable  in  1  one-cycle strobe; rcv_data holds a complete byte.
- rcv_data  in  8  received byte, PID in bits [3:0], check nibble in [7:4].
- r_error  in  1  receiver error (bit-stuff or EOP fault); any-cycle pulse or level.
- fifo_full  in  1  RX FIFO cannot accept a write this cycle.
- pkt_ack  in  1  protocol layer consumed the current result.
- fifo_wr  out  1  one-cycle FIFO write strobe.
- fifo_wdata  out  8  byte written with fifo_wr.
- fifo_flush  out  1  one-cycle pulse; discard bytes written for the current packet.
- pkt_valid  out  1  result fields valid; held until pkt_ack.
- pkt_type  out  3  0 NONE, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 ERR.
- rx_data_len  out  7  payload byte count of a DATA packet (CRC bytes excluded); 0 otherwise.
- rx_active  out  1  high in PID, TOKEN, PAYLOAD and ERR states.

## Operation
- States:
  - IDLE: rcving=1 -> PID.
  - PID: waits for the first w_enable, then checks rcv_data[7:4] == ~rcv_data[3:0].
    - Check fails, or PID not in {0x1 OUT, 0x9 IN, 0x3 DATA0, 0xB DATA1, 0x2 ACK, 0xA NAK} -> ERR.
    - Token -> TOKEN.
    - Data -> PAYLOAD.
    - Handshake -> HSK.
  - TOKEN: counts bytes; no FIFO writes. At packet end, count must be exactly 2, otherwise ERR.
  - HSK: any byte -> ERR. At packet end -> DONE.
  - PAYLOAD: each byte is forwarded to the FIFO and counted. At packet end, count must be in 2..MAX_DATA+2, otherwise ERR.
  - ERR: waits for rcving=0, then -> DONE with pkt_type=7.
  - DONE: pkt_valid=1. On pkt_ack -> IDLE.
- Packet end is the first cycle with rcving=0 in TOKEN, HSK or PAYLOAD. A w_enable in that same cycle is counted before the end check.
- Error rules:
  - r_error=1 in PID, TOKEN, HSK or PAYLOAD -> ERR.
  - w_enable with fifo_full=1 in PAYLOAD -> ERR; that byte is not written.
  - A byte beyond MAX_DATA+2 -> ERR; that byte is not written.
- On entry to ERR, fifo_flush pulses once if at least one fifo_wr occurred for this packet.
- rx_data_len = byte count − 2 for DATA0/DATA1, else 0.
- Byte counter is 7 bits and saturates; it never wraps.
- Packets arriving while in DONE are dropped:
  - No FIFO writes.
  - The block stays in DONE.
  - After ack it returns to IDLE and re-arms only on the next rcving rising edge. A packet in progress at ack time is ignored.
- Reset mid-packet: IDLE, counter cleared, no flush pulse.

## Timing
- Reset values: fifo_wr=0, fifo_wdata=0x00, fifo_flush=0, pkt_valid=0, pkt_type=0, rx_data_len=0, rx_active=0.
- fifo_wr/fifo_wdata are registered and appear one cycle after the qualifying w_enable.
- pkt_valid rises one cycle after the packet-end cycle; for ERR, one cycle after the rcving=0 cycle.
- pkt_type/rx_data_len are stable while pkt_valid=1.
- pkt_ack while pkt_valid=1: pkt_valid is 0 the next cycle. pkt_ack while pkt_valid=0 is ignored.
- fifo_flush is asserted the cycle after the erroring event, and never in the same cycle as fifo_wr.
- Back-to-back packets: minimum one IDLE cycle between DONE exit and the next PID state.

## Configuration
- USB_RX_STATS_EN defined:
  - Adds outputs good_pkt_cnt[7:0], err_pkt_cnt[7:0] and drop_pkt_cnt[7:0].
  - Each counter increments on DONE entry (good or ERR) or on a dropped packet's rcving rising edge.
  - Counters saturate at 0xFF and clear on rst.
- Undefined: no counters and no such ports.

## Test plan
- Bytes 0xE1, 0x15, 0xA8 then rcving falls -> pkt_type=1, rx_data_len=0, no fifo_wr, pkt_valid held until pkt_ack.
- DATA0: 0xC3 + 4 payload + 2 CRC bytes -> 6 fifo_wr in order, pkt_type=3, rx_data_len=4.
- 0xD2 alone -> pkt_type=5. Then 0xD3 (bad check nibble) -> pkt_type=7, no fifo_flush.
- DATA1 (0x4B) + 3 bytes, then r_error pulse -> fifo_flush once, pkt_type=7 after rcving falls.
- MAX_DATA=4, DATA0 + 7 bytes -> 6 writes, 7th byte not written, flush, pkt_type=7. Separately, fifo_full on the 2nd byte -> flush, pkt_type=7.
- Second packet while pkt_valid pending -> no writes, result unchanged. rst mid-PAYLOAD -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/usb_rx_pkt_ctrl.sv
// USB packet-level receive controller: PID check, packet classification, FIFO forwarding.
// Optional per-packet statistics counters are enabled with `define USB_RX_STATS_EN.
module usb_rx_pkt_ctrl #(
  parameter int unsigned MAX_DATA = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcving,
  input  logic       w_enable,
  input  logic [7:0] rcv_data,
  input  logic       r_error,
  input  logic       fifo_full,
  input  logic       pkt_ack,
  output logic       fifo_wr,
  output logic [7:0] fifo_wdata,
  output logic       fifo_flush,
  output logic       pkt_valid,
  output logic [2:0] pkt_type,
  output logic [6:0] rx_data_len,
  output logic       rx_active
`ifdef USB_RX_STATS_EN
  ,
  output logic [7:0] good_pkt_cnt,
  output logic [7:0] err_pkt_cnt,
  output logic [7:0] drop_pkt_cnt
`endif
);

  localparam logic [6:0] MaxCnt = 7'(MAX_DATA + 2);

  localparam logic [2:0] TyNone  = 3'd0;
  localparam logic [2:0] TyOut   = 3'd1;
  localparam logic [2:0] TyIn    = 3'd2;
  localparam logic [2:0] TyData0 = 3'd3;
  localparam logic [2:0] TyData1 = 3'd4;
  localparam logic [2:0] TyAck   = 3'd5;
  localparam logic [2:0] TyNak   = 3'd6;
  localparam logic [2:0] TyErr   = 3'd7;

  typedef enum logic [2:0] {
    StIdle, StPid, StToken, StHsk, StPayload, StErr, StDone
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0] kind_q, kind_d;
  logic       wrote_q, wrote_d;
  logic       armed_q, armed_d;
  logic       wr_d, flush_d;
  logic [7:0] wdata_d;
  logic [2:0] type_d;
  logic [6:0] len_d;
  logic       err, done_ok;

  assign cnt_inc = (cnt_q == 7'h7f) ? cnt_q : cnt_q + 7'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    wrote_d = wrote_q;
    wr_d    = 1'b0;
    wdata_d = fifo_wdata;
    flush_d = 1'b0;
    type_d  = pkt_type;
    len_d   = rx_data_len;
    err     = 1'b0;
    done_ok = 1'b0;
    // A packet still in flight when DONE is acked must end before we re-arm.
    if (!rcving) begin
      armed_d = 1'b1;
    end else if (state_q == StDone && pkt_ack) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end

    unique case (state_q)
      StIdle: begin
        if (rcving && armed_q) begin
          state_d = StPid;
          cnt_d   = 7'd0;
          wrote_d = 1'b0;
        end
      end
      StPid: begin
        if (r_error) begin
          err = 1'b1;
        end else if (w_enable) begin
          if (rcv_data[7:4] != ~rcv_data[3:0]) begin
            err = 1'b1;
          end else begin
            case (rcv_data[3:0])
              4'h1:    begin kind_d = TyOut;   state_d = StToken;   end
              4'h9:    begin kind_d = TyIn;    state_d = StToken;   end
              4'h3:    begin kind_d = TyData0; state_d = StPayload; end
              4'hB:    begin kind_d = TyData1; state_d = StPayload; end
              4'h2:    begin kind_d = TyAck;   state_d = StHsk;     end
              4'hA:    begin kind_d = TyNak;   state_d = StHsk;     end
              default: err = 1'b1;
            endcase
          end
        end else if (!rcving) begin
          err = 1'b1;
        end
      end
      StToken: begin
        if (r_error) begin
          err = 1'b1;
        end else begin
          if (w_enable) cnt_d = cnt_inc;
          if (!rcving) begin
            if (cnt_d == 7'd2) done_ok = 1'b1;
            else               err     = 1'b1;
          end
        end
      end
      StHsk: begin
        if (r_error || w_enable) err = 1'b1;
        else if (!rcving)        done_ok = 1'b1;
      end
      StPayload: begin
        if (r_error) begin
          err = 1'b1;
        end else begin
          if (w_enable) begin
            if (fifo_full || cnt_q >= MaxCnt) begin
              err = 1'b1;
            end else begin
              wr_d    = 1'b1;
              wdata_d = rcv_data;
              wrote_d = 1'b1;
              cnt_d   = cnt_inc;
            end
          end
          // Overflow is caught per byte above, so only the lower bound remains.
          if (!err && !rcving) begin
            if (cnt_d >= 7'd2) done_ok = 1'b1;
            else               err     = 1'b1;
          end
        end
      end
      StErr: begin
        if (!rcving) state_d = StDone;
      end
      StDone: begin
        if (pkt_ack) begin
          state_d = StIdle;
          type_d  = TyNone;
          len_d   = 7'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err) begin
      state_d = rcving ? StErr : StDone;
      type_d  = TyErr;
      len_d   = 7'd0;
      flush_d = wrote_q;
    end
    if (done_ok) begin
      state_d = StDone;
      type_d  = kind_q;
      len_d   = (kind_q == TyData0 || kind_q == TyData1) ? cnt_d - 7'd2 : 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 7'd0;
      kind_q      <= TyNone;
      wrote_q     <= 1'b0;
      armed_q     <= 1'b1;
      fifo_wr     <= 1'b0;
      fifo_wdata  <= 8'h00;
      fifo_flush  <= 1'b0;
      pkt_valid   <= 1'b0;
      pkt_type    <= TyNone;
      rx_data_len <= 7'd0;
      rx_active   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
      wrote_q     <= wrote_d;
      armed_q     <= armed_d;
      fifo_wr     <= wr_d;
      fifo_wdata  <= wdata_d;
      fifo_flush  <= flush_d;
      pkt_valid   <= (state_d == StDone);
      pkt_type    <= type_d;
      rx_data_len <= len_d;
      rx_active   <= (state_d == StPid) || (state_d == StToken) ||
                     (state_d == StPayload) || (state_d == StErr);
    end
  end

`ifdef USB_RX_STATS_EN
  logic rcving_q;
  logic done_entry;

  assign done_entry = (state_d == StDone) && (state_q != StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      rcving_q     <= 1'b0;
      good_pkt_cnt <= 8'h00;
      err_pkt_cnt  <= 8'h00;
      drop_pkt_cnt <= 8'h00;
    end else begin
      rcving_q <= rcving;
      if (done_entry && type_d != TyErr && good_pkt_cnt != 8'hff) begin
        good_pkt_cnt <= good_pkt_cnt + 8'd1;
      end
      if (done_entry && type_d == TyErr && err_pkt_cnt != 8'hff) begin
        err_pkt_cnt <= err_pkt_cnt + 8'd1;
      end
      if (state_q == StDone && rcving && !rcving_q && drop_pkt_cnt != 8'hff) begin
        drop_pkt_cnt <= drop_pkt_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for usb_rx_pkt_ctrl, built with MAX_DATA=4 so overflow is cheap to reach.
module tb_usb_rx_pkt_ctrl;

  logic       clk, rst, rcving, w_enable, r_error, fifo_full, pkt_ack;
  logic [7:0] rcv_data;
  logic       fifo_wr, fifo_flush, pkt_valid, rx_active;
  logic [7:0] fifo_wdata;
  logic [2:0] pkt_type;
  logic [6:0] rx_data_len;

  int n_chk  = 0;
  int n_pass = 0;
  int n_flush = 0;
  int n_both  = 0;
  logic [7:0] wq[$];

  usb_rx_pkt_ctrl #(.MAX_DATA(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rcving     (rcving),
    .w_enable   (w_enable),
    .rcv_data   (rcv_data),
    .r_error    (r_error),
    .fifo_full  (fifo_full),
    .pkt_ack    (pkt_ack),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .fifo_flush (fifo_flush),
    .pkt_valid  (pkt_valid),
    .pkt_type   (pkt_type),
    .rx_data_len(rx_data_len),
    .rx_active  (rx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr) wq.push_back(fifo_wdata);
    if (fifo_flush) n_flush++;
    if (fifo_wr && fifo_flush) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    w_enable = 1'b1;
    rcv_data = b;
    tick();
    w_enable = 1'b0;
    tick();
  endtask

  task automatic start_pkt();
    wq.delete();
    n_flush = 0;
    rcving = 1'b1;
    tick();
  endtask

  task automatic end_pkt();
    rcving = 1'b0;
    tick();
  endtask

  task automatic ack(input string tag);
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 32'(pkt_valid), 32'd0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"},    32'(fifo_wr),     32'd0);
    check({tag, "_wdata"}, 32'(fifo_wdata),  32'd0);
    check({tag, "_flush"}, 32'(fifo_flush),  32'd0);
    check({tag, "_valid"}, 32'(pkt_valid),   32'd0);
    check({tag, "_type"},  32'(pkt_type),    32'd0);
    check({tag, "_len"},   32'(rx_data_len), 32'd0);
    check({tag, "_act"},   32'(rx_active),   32'd0);
  endtask

  logic [7:0] d0_bytes[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};

  initial begin
    rst = 1'b1; rcving = 1'b0; w_enable = 1'b0; r_error = 1'b0;
    fifo_full = 1'b0; pkt_ack = 1'b0; rcv_data = 8'h00;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // OUT token
    start_pkt();
    check("tok_active", 32'(rx_active), 32'd1);
    send_byte(8'hE1); send_byte(8'h15); send_byte(8'hA8);
    end_pkt();
    check("tok_valid", 32'(pkt_valid), 32'd1);
    check("tok_type", 32'(pkt_type), 32'd1);
    check("tok_len", 32'(rx_data_len), 32'd0);
    check("tok_nowr", 32'(wq.size()), 32'd0);
    tick(); tick(); tick();
    check("tok_hold_valid", 32'(pkt_valid), 32'd1);
    check("tok_hold_type", 32'(pkt_type), 32'd1);
    ack("tok");

    // DATA0 with 4 payload + 2 CRC
    start_pkt();
    send_byte(8'hC3);
    for (int i = 0; i < 6; i++) send_byte(d0_bytes[i]);
    end_pkt();
    check("d0_nwr", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("d0_byte%0d", i), 32'(wq[i]), 32'(d0_bytes[i]));
    check("d0_type", 32'(pkt_type), 32'd3);
    check("d0_len", 32'(rx_data_len), 32'd4);
    check("d0_valid", 32'(pkt_valid), 32'd1);
    ack("d0");

    // ACK handshake
    start_pkt();
    send_byte(8'hD2);
    end_pkt();
    check("ack_type", 32'(pkt_type), 32'd5);
    check("ack_valid", 32'(pkt_valid), 32'd1);
    ack("ack");

    // Bad check nibble: nothing written, so no flush
    start_pkt();
    send_byte(8'hD3);
    end_pkt();
    check("badpid_type", 32'(pkt_type), 32'd7);
    check("badpid_valid", 32'(pkt_valid), 32'd1);
    check("badpid_noflush", 32'(n_flush), 32'd0);
    ack("badpid");

    // DATA1 + 3 bytes then receiver error
    start_pkt();
    send_byte(8'h4B); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    r_error = 1'b1;
    tick();
    r_error = 1'b0;
    check("rerr_flush_now", 32'(fifo_flush), 32'd1);
    check("rerr_valid_early", 32'(pkt_valid), 32'd0);
    tick(); tick();
    end_pkt();
    check("rerr_nflush", 32'(n_flush), 32'd1);
    check("rerr_nwr", 32'(wq.size()), 32'd3);
    check("rerr_type", 32'(pkt_type), 32'd7);
    check("rerr_valid", 32'(pkt_valid), 32'd1);
    ack("rerr");

    // Overflow at MAX_DATA=4: 7th byte rejected
    start_pkt();
    send_byte(8'hC3);
    for (int i = 1; i <= 7; i++) send_byte(8'(8'h80 + i));
    end_pkt();
    check("ovf_nwr", 32'(wq.size()), 32'd6);
    check("ovf_last", 32'(wq[5]), 32'h86);
    check("ovf_nflush", 32'(n_flush), 32'd1);
    check("ovf_type", 32'(pkt_type), 32'd7);
    ack("ovf");

    // FIFO full on second payload byte
    start_pkt();
    send_byte(8'hC3); send_byte(8'h55);
    fifo_full = 1'b1;
    send_byte(8'h66);
    fifo_full = 1'b0;
    end_pkt();
    check("full_nwr", 32'(wq.size()), 32'd1);
    check("full_nflush", 32'(n_flush), 32'd1);
    check("full_type", 32'(pkt_type), 32'd7);
    ack("full");
    check("flush_wr_overlap", 32'(n_both), 32'd0);

    // Packet arriving while a result is pending is dropped
    start_pkt();
    send_byte(8'h69); send_byte(8'h01); send_byte(8'h02);
    end_pkt();
    check("drop_first_type", 32'(pkt_type), 32'd2);
    start_pkt();
    send_byte(8'hC3); send_byte(8'h11); send_byte(8'h22);
    end_pkt();
    check("drop_nwr", 32'(wq.size()), 32'd0);
    check("drop_valid", 32'(pkt_valid), 32'd1);
    check("drop_type", 32'(pkt_type), 32'd2);
    ack("drop");
    check("drop_idle", 32'(rx_active), 32'd0);

    // Reset in the middle of a data packet
    start_pkt();
    send_byte(8'hC3);
    w_enable = 1'b1; rcv_data = 8'h77;
    tick();
    w_enable = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0; rcving = 1'b0;
    tick(); tick();
    check("midrst_noflush", 32'(n_flush), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
